// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared types for the RV32I decode stage.
//   RESET        - active level of the synchronous reset
//   opcode_t     - 7-bit RV32I major opcodes
//   alu_op_t     - 4-bit ALU operation handed to execute
//   imm_fmt_t    - immediate encoding selector for the immediate generator
//   ctrl_t       - decoded control bundle (combinational)
//   id_ex_t      - ID/EX pipeline register contents
//   decode_ctrl  - pure combinational control decoder
package decode_stage_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic RESET = 1'b0;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    alu_op_t  alu_op;
    imm_fmt_t imm_fmt;
    logic     alu_src_imm;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     illegal;
    logic     uses_rs1;
    logic     uses_rs2;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rd;
    alu_op_t          alu_op;
    logic             alu_src_imm;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             illegal;
  } id_ex_t;

  // funct3 -> ALU op. bit30 selects SUB only for register-register ops;
  // SRA/SRAI are selected by bit30 in both formats.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3,
                                              input logic       bit30,
                                              input logic       is_op);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = (is_op && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic       bit30,
                                        input logic       rd_nonzero);
    ctrl_t c;
    c          = '0;
    c.alu_op   = ALU_ADD;
    c.imm_fmt  = IMM_NONE;
    c.uses_rs1 = 1'b1;
    case (opcode)
      OPC_LUI: begin
        c.imm_fmt = IMM_U; c.alu_op = ALU_PASS_B; c.alu_src_imm = 1'b1;
        c.reg_write = 1'b1; c.uses_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        c.imm_fmt = IMM_U; c.alu_src_imm = 1'b1;
        c.reg_write = 1'b1; c.uses_rs1 = 1'b0;
      end
      OPC_JAL: begin
        c.imm_fmt = IMM_J; c.alu_src_imm = 1'b1; c.jump = 1'b1;
        c.reg_write = 1'b1; c.uses_rs1 = 1'b0;
      end
      OPC_JALR: begin
        c.imm_fmt = IMM_I; c.alu_src_imm = 1'b1; c.jump = 1'b1;
        c.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        c.imm_fmt = IMM_B; c.alu_op = ALU_SUB; c.branch = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        c.imm_fmt = IMM_I; c.alu_src_imm = 1'b1; c.mem_read = 1'b1;
        c.reg_write = 1'b1;
      end
      OPC_STORE: begin
        c.imm_fmt = IMM_S; c.alu_src_imm = 1'b1; c.mem_write = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        c.imm_fmt = IMM_I; c.alu_src_imm = 1'b1; c.reg_write = 1'b1;
        c.alu_op = alu_from_funct3(funct3, bit30, 1'b0);
      end
      OPC_OP: begin
        c.reg_write = 1'b1; c.uses_rs2 = 1'b1;
        c.alu_op = alu_from_funct3(funct3, bit30, 1'b1);
      end
      default: begin
        c.illegal = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally discarded; suppress them here so
    // downstream hazard/forwarding logic never sees a live x0 write.
    if (!rd_nonzero) c.reg_write = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch -> decode valid/ready instruction handshake.
//   if_valid  - fetch presents an instruction
//   if_ready  - decode accepts this cycle
//   if_pc     - PC of the presented instruction
//   if_instr  - presented instruction word
// master = fetch side, slave = decode side.
interface decode_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_valid;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_instr;

  modport master (output if_valid, if_pc, if_instr, input if_ready);
  modport slave  (input if_valid, if_pc, if_instr, output if_ready);
endinterface

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: RV32I immediate generator (combinational).
//   instr - instruction bits [31:7] (opcode bits carry no immediate data)
//   fmt   - immediate encoding (I/S/B/U/J/NONE)
//   imm   - sign-extended immediate, 0 for NONE (R-type / illegal)
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:7] instr,
  input  imm_fmt_t              fmt,
  output logic [DATA_WIDTH-1:0] imm
);

  logic s;
  assign s = instr[DATA_WIDTH-1];

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{(DATA_WIDTH-12){s}}, instr[31:20]};
      IMM_S: imm = {{(DATA_WIDTH-12){s}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(DATA_WIDTH-12){s}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{(DATA_WIDTH-20){s}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode pipeline stage.
//   clk, rst          - clock, synchronous active-low reset
//   fetch             - valid/ready instruction handshake from fetch
//   flush             - redirect from execute; kills ID and incoming instr
//   rf_read1/2_id     - register file read indices (combinational)
//   rf_read1/2_data   - register file read data (write-bypassed)
//   ex_ready          - execute accepts the ID/EX contents
//   id_*              - ID/EX pipeline register outputs
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  decode_stage_if.slave            fetch,
  input  logic                     flush,
  output logic [ADDRESS_WIDTH-1:0] rf_read1_id,
  output logic [ADDRESS_WIDTH-1:0] rf_read2_id,
  input  logic [DATA_WIDTH-1:0]    rf_read1_data,
  input  logic [DATA_WIDTH-1:0]    rf_read2_data,
  input  logic                     ex_ready,
  output logic                     id_valid,
  output logic [DATA_WIDTH-1:0]    id_pc,
  output logic [DATA_WIDTH-1:0]    id_rs1_data,
  output logic [DATA_WIDTH-1:0]    id_rs2_data,
  output logic [DATA_WIDTH-1:0]    id_imm,
  output logic [ADDRESS_WIDTH-1:0] id_rd,
  output logic [3:0]               id_alu_op,
  output logic                     id_alu_src_imm,
  output logic                     id_reg_write,
  output logic                     id_mem_read,
  output logic                     id_mem_write,
  output logic                     id_branch,
  output logic                     id_jump,
  output logic                     id_illegal
);

  id_ex_t                id_ex_q;
  id_ex_t                id_ex_d;
  logic                  id_valid_q;
  ctrl_t                 ctrl;
  logic [DATA_WIDTH-1:0] imm;
  logic                  advance;
  logic                  hazard;

  assign rf_read1_id = fetch.if_instr[19:15];
  assign rf_read2_id = fetch.if_instr[24:20];

  assign ctrl = decode_ctrl(fetch.if_instr[6:0], fetch.if_instr[14:12],
                            fetch.if_instr[30], fetch.if_instr[11:7] != '0);

  decode_stage_imm_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_imm_gen (
    .instr (fetch.if_instr[DATA_WIDTH-1:7]),
    .fmt   (ctrl.imm_fmt),
    .imm   (imm)
  );

  assign advance = !id_valid_q || ex_ready;

  // Load-use: a load in ID produces its result too late for the next
  // instruction to read it at this edge, so hold that instruction back.
  assign hazard = id_valid_q && id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                  fetch.if_valid &&
                  ((ctrl.uses_rs1 && (rf_read1_id == id_ex_q.rd)) ||
                   (ctrl.uses_rs2 && (rf_read2_id == id_ex_q.rd)));

  // During flush the incoming instruction is consumed and discarded.
  assign fetch.if_ready = flush || (advance && !hazard);

  always_comb begin
    id_ex_d             = id_ex_q;
    id_ex_d.pc          = fetch.if_pc;
    id_ex_d.rs1_data    = rf_read1_data;
    id_ex_d.rs2_data    = rf_read2_data;
    id_ex_d.imm         = imm;
    id_ex_d.rd          = fetch.if_instr[11:7];
    id_ex_d.alu_op      = ctrl.alu_op;
    id_ex_d.alu_src_imm = ctrl.alu_src_imm;
    id_ex_d.reg_write   = ctrl.reg_write;
    id_ex_d.mem_read    = ctrl.mem_read;
    id_ex_d.mem_write   = ctrl.mem_write;
    id_ex_d.branch      = ctrl.branch;
    id_ex_d.jump        = ctrl.jump;
    id_ex_d.illegal     = ctrl.illegal;
  end

  // Data fields load only on accept; bubbles and flushes clear just the
  // valid bit and leave stale data behind.
  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      id_ex_q    <= '0;
      id_valid_q <= 1'b0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
    end else if (advance) begin
      if (hazard) begin
        id_valid_q <= 1'b0;
      end else if (fetch.if_valid) begin
        id_ex_q    <= id_ex_d;
        id_valid_q <= 1'b1;
      end else begin
        id_valid_q <= 1'b0;
      end
    end
  end

  assign id_valid       = id_valid_q;
  assign id_pc          = id_ex_q.pc;
  assign id_rs1_data    = id_ex_q.rs1_data;
  assign id_rs2_data    = id_ex_q.rs2_data;
  assign id_imm         = id_ex_q.imm;
  assign id_rd          = id_ex_q.rd;
  assign id_alu_op      = id_ex_q.alu_op;
  assign id_alu_src_imm = id_ex_q.alu_src_imm;
  assign id_reg_write   = id_ex_q.reg_write;
  assign id_mem_read    = id_ex_q.mem_read;
  assign id_mem_write   = id_ex_q.mem_write;
  assign id_branch      = id_ex_q.branch;
  assign id_jump        = id_ex_q.jump;
  assign id_illegal     = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_ready;
  logic [4:0]  rf_read1_id, rf_read2_id;
  logic [31:0] rf_read1_data, rf_read2_data;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        id_branch, id_jump, id_illegal;

  int n_assert = 0;
  int n_fail   = 0;

  decode_stage_if #(.DATA_WIDTH(32)) fe ();

  decode_stage #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch          (fe),
    .flush          (flush),
    .rf_read1_id    (rf_read1_id),
    .rf_read2_id    (rf_read2_id),
    .rf_read1_data  (rf_read1_data),
    .rf_read2_data  (rf_read2_data),
    .ex_ready       (ex_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_rd          (id_rd),
    .id_alu_op      (id_alu_op),
    .id_alu_src_imm (id_alu_src_imm),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .id_branch      (id_branch),
    .id_jump        (id_jump),
    .id_illegal     (id_illegal)
  );

  always #5 clk = ~clk;

  // Register file stand-in: contents encode the register index.
  assign rf_read1_data = 32'h1000_0000 + 32'(rf_read1_id);
  assign rf_read2_data = 32'h2000_0000 + 32'(rf_read2_id);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then move 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr);
    fe.if_valid = 1'b1;
    fe.if_pc    = pc;
    fe.if_instr = instr;
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    flush       = 1'b0;
    ex_ready    = 1'b1;
    fe.if_valid = 1'b0;
    fe.if_pc    = '0;
    fe.if_instr = '0;
    step();
    step();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_imm", id_imm, 32'd0);
    chk("rst_if_ready", 32'(fe.if_ready), 32'd1);
    rst = 1'b1;

    // addi x5,x0,-1
    present(32'h100, 32'hFFF0_0293);
    chk("addi_rf1_id", 32'(rf_read1_id), 32'd0);
    chk("addi_rf2_id", 32'(rf_read2_id), 32'd31);
    chk("addi_if_ready", 32'(fe.if_ready), 32'd1);
    step();
    chk("addi_valid", 32'(id_valid), 32'd1);
    chk("addi_rd", 32'(id_rd), 32'd5);
    chk("addi_imm", id_imm, 32'hFFFF_FFFF);
    chk("addi_alu", 32'(id_alu_op), 32'd0);
    chk("addi_src_imm", 32'(id_alu_src_imm), 32'd1);
    chk("addi_reg_write", 32'(id_reg_write), 32'd1);
    chk("addi_pc", id_pc, 32'h100);
    chk("addi_rs1_data", id_rs1_data, 32'h1000_0000);

    // lw x3,0(x1) then dependent add x4,x3,x2
    present(32'h104, 32'h0000_A183);
    step();
    chk("lw_valid", 32'(id_valid), 32'd1);
    chk("lw_mem_read", 32'(id_mem_read), 32'd1);
    chk("lw_rd", 32'(id_rd), 32'd3);
    chk("lw_rs1_data", id_rs1_data, 32'h1000_0001);
    present(32'h108, 32'h0021_8233);
    chk("hazard_if_ready", 32'(fe.if_ready), 32'd0);
    step();
    chk("bubble_valid", 32'(id_valid), 32'd0);
    chk("post_bubble_if_ready", 32'(fe.if_ready), 32'd1);
    step();
    chk("add_valid", 32'(id_valid), 32'd1);
    chk("add_rd", 32'(id_rd), 32'd4);
    chk("add_pc", id_pc, 32'h108);
    chk("add_alu", 32'(id_alu_op), 32'd0);
    chk("add_src_imm", 32'(id_alu_src_imm), 32'd0);
    chk("add_imm", id_imm, 32'd0);
    chk("add_rs1_data", id_rs1_data, 32'h1000_0003);
    chk("add_rs2_data", id_rs2_data, 32'h2000_0002);

    // beq x1,x2,-4, then flush kills ID and the incoming addi x6,x0,7
    present(32'h10C, 32'hFE20_8EE3);
    step();
    chk("beq_imm", id_imm, 32'hFFFF_FFFC);
    chk("beq_branch", 32'(id_branch), 32'd1);
    chk("beq_reg_write", 32'(id_reg_write), 32'd0);
    chk("beq_alu", 32'(id_alu_op), 32'd1);
    present(32'h110, 32'h0070_0313);
    flush = 1'b1;
    #1;
    chk("flush_if_ready", 32'(fe.if_ready), 32'd1);
    step();
    flush       = 1'b0;
    fe.if_valid = 1'b0;
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_stale_imm", id_imm, 32'hFFFF_FFFC);
    step();
    chk("flush_dropped", 32'(id_valid), 32'd0);

    // Execute stall for 3 cycles
    present(32'h110, 32'h0070_0313);
    step();
    chk("addi6_rd", 32'(id_rd), 32'd6);
    chk("addi6_imm", id_imm, 32'd7);
    ex_ready = 1'b0;
    present(32'h114, 32'h00F0_E393);
    for (int i = 0; i < 3; i++) begin
      chk("stall_if_ready", 32'(fe.if_ready), 32'd0);
      step();
      chk("stall_valid", 32'(id_valid), 32'd1);
      chk("stall_rd", 32'(id_rd), 32'd6);
      chk("stall_pc", id_pc, 32'h110);
    end
    ex_ready = 1'b1;
    #1;
    chk("release_if_ready", 32'(fe.if_ready), 32'd1);
    step();
    chk("ori_rd", 32'(id_rd), 32'd7);
    chk("ori_imm", id_imm, 32'h0000_000F);
    chk("ori_alu", 32'(id_alu_op), 32'd8);
    chk("ori_rs1_data", id_rs1_data, 32'h1000_0001);

    // Illegal opcode 0x7F with rd=6
    present(32'h118, 32'h0000_037F);
    step();
    chk("illegal_flag", 32'(id_illegal), 32'd1);
    chk("illegal_reg_write", 32'(id_reg_write), 32'd0);
    chk("illegal_mem", {30'd0, id_mem_read, id_mem_write}, 32'd0);

    // add x0,x1,x2
    present(32'h11C, 32'h0020_8033);
    step();
    chk("addx0_illegal", 32'(id_illegal), 32'd0);
    chk("addx0_reg_write", 32'(id_reg_write), 32'd0);
    chk("addx0_rd", 32'(id_rd), 32'd0);

    // srai x9,x1,3
    present(32'h120, 32'h4030_D493);
    step();
    chk("srai_alu", 32'(id_alu_op), 32'd7);
    chk("srai_imm", id_imm, 32'h0000_0403);

    // lui x10,0x12345
    present(32'h124, 32'h1234_5537);
    step();
    chk("lui_alu", 32'(id_alu_op), 32'd10);
    chk("lui_imm", id_imm, 32'h1234_5000);

    // sw x2,8(x1)
    present(32'h128, 32'h0020_A423);
    step();
    chk("sw_imm", id_imm, 32'd8);
    chk("sw_mem_write", 32'(id_mem_write), 32'd1);
    chk("sw_reg_write", 32'(id_reg_write), 32'd0);

    // jal x1,-8
    present(32'h12C, 32'hFF9F_F0EF);
    step();
    chk("jal_imm", id_imm, 32'hFFFF_FFF8);
    chk("jal_jump", 32'(id_jump), 32'd1);
    chk("jal_reg_write", 32'(id_reg_write), 32'd1);

    // Flush during a load-use hazard: flush wins, no bubble then capture
    present(32'h130, 32'h0000_A183);
    step();
    present(32'h134, 32'h0021_8233);
    chk("hz2_if_ready", 32'(fe.if_ready), 32'd0);
    flush = 1'b1;
    #1;
    chk("hz2_flush_if_ready", 32'(fe.if_ready), 32'd1);
    step();
    flush       = 1'b0;
    fe.if_valid = 1'b0;
    chk("hz2_flush_valid", 32'(id_valid), 32'd0);
    chk("hz2_stale_pc", id_pc, 32'h130);

    // Reset while stalled with a live instruction
    present(32'h138, 32'h0070_0313);
    step();
    ex_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(id_valid), 32'd1);
    rst = 1'b0;
    step();
    chk("midrst_valid", 32'(id_valid), 32'd0);
    chk("midrst_pc", id_pc, 32'd0);
    chk("midrst_imm", id_imm, 32'd0);
    chk("midrst_rd", 32'(id_rd), 32'd0);
    chk("midrst_rs1_data", id_rs1_data, 32'd0);
    chk("midrst_flags", {21'd0, id_alu_op, id_alu_src_imm, id_reg_write,
                         id_mem_read, id_mem_write, id_branch, id_jump,
                         id_illegal}, 32'd0);
    rst         = 1'b1;
    ex_ready    = 1'b1;
    fe.if_valid = 1'b0;
    #1;
    chk("postrst_if_ready", 32'(fe.if_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage for the RV32I core. It accepts instructions from fetch over a valid/ready handshake and drives the register file read ports combinationally. It latches operands, the sign-extended immediate and control fields into an ID/EX pipeline register for the execute stage, inserting load-use bubbles and honouring branch flushes. It sits between fetch and the register file/execute stage.

## Interface

Parameters:
- DATA_WIDTH, 32, datapath and instruction width
- ADDRESS_WIDTH, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low (asserted when rst == RESET, RESET = 1'b0)
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  decode accepts this cycle
- if_pc  in  DATA_WIDTH  PC of presented instruction
- if_instr  in  DATA_WIDTH  presented instruction
- flush  in  1  branch/jump redirect from execute; kill ID contents and the incoming instruction
- rf_read1_id / rf_read2_id  out  ADDRESS_WIDTH  instr[19:15] / instr[24:20], combinational from if_instr
- rf_read1_data / rf_read2_data  in  DATA_WIDTH  register file outputs (write-bypassed)
- ex_ready  in  1  execute accepts ID/EX contents
- id_valid  out  1  ID/EX register holds a live instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  out  DATA_WIDTH  latched PC, operands, immediate
- id_rd  out  ADDRESS_WIDTH  destination register
- id_alu_op  out  4  alu_op_t
- id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal  out  1  control flags

## Operation

- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode sets id_illegal=1 and clears reg_write, mem_read and mem_write.
- Immediate formats: I, S, B, U, J, sign-extended from instr[31]. R-type gives imm=0.
- alu_op: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B (LUI). SUB/SRA are selected by instr[30] for OP; for OP-IMM only SRAI uses instr[30].
- uses_rs1 = not (LUI, AUIPC, JAL). uses_rs2 = BRANCH, STORE, OP.
- id_reg_write is forced 0 when rd == 0.
- advance = !id_valid || ex_ready.
- hazard = id_valid && id_mem_read && id_rd != 0 && if_valid && ((uses_rs1 && rs1 == id_rd) || (uses_rs2 && rs2 == id_rd)).
- if_ready = advance && !hazard, or 1 when flush.
- Next-state priority per cycle:
  - reset: all ID/EX fields and id_valid go to 0.
  - flush: id_valid <= 0; incoming instruction discarded.
  - advance && hazard: id_valid <= 0 (bubble).
  - advance && if_valid: capture all fields, id_valid <= 1.
  - advance && !if_valid: id_valid <= 0.
  - otherwise: hold all outputs.
- Data fields are captured only on accept, so they hold stale values while id_valid=0.

## Timing

- Read ids are combinational (0 cycles). Register data is sampled at the same edge as the accept, so a same-cycle writeback is seen via the register file bypass.
- Decode latency: 1 cycle from accepted if_valid&&if_ready to id_valid.
- Load-use: exactly one bubble cycle; the dependent instruction is accepted the cycle after the load leaves ID.
- Flush during a hazard or stall: flush wins, and no bubble is counted.
- Reset mid-operation: every output is 0 at the next edge. if_ready=1 after reset.
- Throughput: 1 instruction/cycle when ex_ready=1 and there is no hazard.

## Structure

- Shared package common: RESET, opcode_t enum (7-bit RV32I opcodes), alu_op_t enum (4-bit), imm_fmt_t (I, S, B, U, J, NONE), and an id_ex_t packed struct of the ID/EX fields.
- One sub-module, imm_gen: combinational instr + imm_fmt_t -> DATA_WIDTH immediate.
- The decode control is a combinational function. The sequential part is a single id_ex_t register plus id_valid.

## Test plan

- addi x5,x0,-1 (0xFFF00293), ex_ready=1 -> next cycle: id_valid=1, id_rd=5, id_imm=0xFFFFFFFF, id_alu_op=ADD, id_alu_src_imm=1, id_reg_write=1.
- lw x3,0(x1) followed by add x4,x3,x2 -> one cycle with if_ready=0 and a bubble (id_valid=0); the add is decoded the following cycle with id_rd=4.
- beq x1,x2,-4 (0xFE208EE3) -> id_imm=0xFFFFFFFC, id_branch=1, id_reg_write=0. Raise flush the next cycle -> id_valid=0 and the incoming instruction is dropped.
- ex_ready=0 for 3 cycles with a valid instruction in ID -> if_ready=0 and id_* held stable; on release the next instruction is captured.
- Opcode 0x7F, and add x0,x1,x2 -> id_illegal=1 with reg_write=0; add x0 gives id_reg_write=0.
- rst=0 asserted while id_valid=1 and stalled -> next edge: id_valid=0 and all fields 0; if_ready=1 after rst=1.
